velocity_cell_streamer: RTL and testbench
=========================================

Name: velocity_cell_streamer

Overview:
Read-side initiator for a per-cell velocity RAM: single port, 1-cycle read latency. Address 0 holds the cell's particle count; addresses 1..N hold {vz, vy, vx}.
- On start, reads the count, then streams every particle velocity out on a valid/ready interface with full backpressure.
- Sits between a cell velocity RAM and the motion-update pipeline.
- Never writes the RAM.

Parameters:
DATA_WIDTH, 96, RAM word width; {vz, vy, vx}, 32 bits each.
PARTICLE_NUM, 220, RAM depth in words, including the count word.
ADDR_WIDTH, 8, RAM address width.
READ_LATENCY, 1, RAM address-to-q latency in cycles; legal values 1..3.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse that begins a cell scan; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last beat is accepted, or after a zero count
particle_count  out  ADDR_WIDTH  count latched from address 0, after clamping
ram_address  out  ADDR_WIDTH  RAM address
ram_rden  out  1  RAM read enable
ram_wren  out  1  constant 0
ram_q  in  DATA_WIDTH  RAM read data
out_valid  out  1  stream data valid
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  {vz, vy, vx}
out_index  out  ADDR_WIDTH  RAM address this beat came from (1..N)
out_last  out  1  high on the final beat (index == N)
cnt_err  out  1  count overflow flag; see Optional Feature

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. busy, done, out_valid, out_last, ram_rden, cnt_err = 0. ram_address, out_data, out_index, particle_count = 0. Skid FIFO emptied; in-flight reads discarded.
- IDLE: on start=1, drive ram_address=0 and ram_rden=1 that cycle; go to CNT_WAIT.
- CNT_WAIT: wait READ_LATENCY cycles, then latch N = ram_q[ADDR_WIDTH-1:0].
  - If N > PARTICLE_NUM-1, clamp N to PARTICLE_NUM-1.
  - If N == 0, pulse done and go to IDLE; no beats are emitted.
  - Otherwise set the next read address to 1 and go to STREAM.
- STREAM:
  - Skid FIFO depth is READ_LATENCY+1.
  - Issue a read (ram_rden=1, ram_address=next address, then increment) only when FIFO occupancy + reads in flight < READ_LATENCY+1 and next address ≤ N.
  - Returning data is tagged with its address and pushed to the FIFO.
  - FIFO head drives out_data / out_index / out_last; out_valid = FIFO non-empty.
  - A beat transfers when out_valid && out_ready. A simultaneous pop and push are allowed in the same cycle.
  - out_data stays stable while out_valid=1 and out_ready=0; there is no combinational path from out_ready to out_data.
  - After the address-N read is issued, go to DRAIN.
- DRAIN: no further reads. When the beat with out_last=1 transfers, pulse done next cycle, drop busy the same cycle, and go to IDLE.
- Throughput: with out_ready held at 1, one beat per cycle after the initial fill.
  - The first beat appears 2*READ_LATENCY+2 cycles after start.
  - done appears N+2*READ_LATENCY+2 cycles after start.
- ram_rden is low whenever no read is issued. ram_address holds its last value when idle.
- start arriving in the same cycle as done: ignored; a new scan requires start while busy=0.

Optional Feature:
VELOCITY_STREAM_OVF_EN
- Defined: cnt_err is a sticky flag, set when the raw count exceeds PARTICLE_NUM-1. It is cleared only by reset or by the next accepted start. Clamping still applies.
- Undefined: cnt_err is tied to 0; clamping still applies.

Test Plan:
- Count word = 5, words 1..5 = 0x..01..0x..05, out_ready=1 → 5 beats with out_index 1..5 on consecutive cycles; out_last only on index 5; done 1 cycle after the last beat; particle_count=5.
- Count = 0 → no out_valid; done pulses READ_LATENCY+1 cycles after start; busy then low.
- Count = 8, out_ready toggling 1,0,0,1,... → all 8 beats in order, no duplicates or drops; out_data stable through each stall; FIFO never exceeds READ_LATENCY+1 entries.
- Count = 250 with PARTICLE_NUM=220 → 219 beats, particle_count=219; cnt_err=1 with VELOCITY_STREAM_OVF_EN defined, 0 without.
- Assert rst at beat 3 of a 10-particle scan → all outputs 0 immediately; a later start rescans from index 1 correctly.
- Pulse start while busy → ignored; the in-progress scan completes unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/velocity_cell_streamer_if.sv
// Purpose     : bundle of the streamer's control, RAM-read and output-stream signals.
// Latency     : none (wires only).
// Backpressure: carries out_valid/out_ready; the downstream may stall the stream indefinitely.
// Ports       : start/busy/done/particle_count/cnt_err (control), ram_address/ram_rden/
//               ram_wren/ram_q (RAM read side), out_valid/out_ready/out_data/out_index/
//               out_last (velocity stream). master = streamer side, slave = environment side.
interface velocity_cell_streamer_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] particle_count;
   logic                  cnt_err;

   logic [ADDR_WIDTH-1:0] ram_address;
   logic                  ram_rden;
   logic                  ram_wren;
   logic [DATA_WIDTH-1:0] ram_q;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;

   modport master (
      input  start, ram_q, out_ready,
      output busy, done, particle_count, cnt_err,
             ram_address, ram_rden, ram_wren,
             out_valid, out_data, out_index, out_last
   );

   modport slave (
      output start, ram_q, out_ready,
      input  busy, done, particle_count, cnt_err,
             ram_address, ram_rden, ram_wren,
             out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/velocity_cell_streamer.sv
// Purpose     : reads a cell's particle count from RAM address 0, then streams words 1..N
//               ({vz,vy,vx}) tagged with their address. Never writes the RAM.
// Latency     : first beat 2*READ_LATENCY+2 cycles after start, then one beat per cycle;
//               done N+2*READ_LATENCY+2 cycles after start (READ_LATENCY+1 for a zero count).
// Backpressure: full valid/ready; reads are issued only against free skid-FIFO credit
//               (READ_LATENCY+1 entries), so stalls never drop or duplicate a beat.
// Ports       : clk, rst (asynchronous, active high), bus (velocity_cell_streamer_if.master).
// Option      : define VELOCITY_STREAM_OVF_EN to make cnt_err a sticky count-overflow flag;
//               otherwise cnt_err is tied low. Count clamping applies in both builds.
module velocity_cell_streamer #(
   parameter int DATA_WIDTH   = 96,
   parameter int PARTICLE_NUM = 220,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   velocity_cell_streamer_if.master bus
);

   localparam int                    DEPTH     = READ_LATENCY + 1;
   localparam int                    PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_N     = ADDR_WIDTH'(PARTICLE_NUM - 1);
   localparam logic [3:0]            DEPTH_W   = 4'(DEPTH);
   localparam logic [1:0]            WAIT_LAST = 2'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CNT_WAIT,
      S_STREAM,
      S_DRAIN
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d;
   // One extra bit so the post-increment after address N never wraps.
   logic [ADDR_WIDTH:0]   next_addr_q, next_addr_d;
   logic [ADDR_WIDTH-1:0] addr_hold_q;
   logic                  done_q, done_d;

   // Shadow of the RAM read pipeline: which stages carry a stream read, and its address.
   logic [READ_LATENCY-1:0] rd_vld_q;
   logic [ADDR_WIDTH-1:0]   rd_tag_q [READ_LATENCY];
   logic [2:0]              infl;

   // Skid FIFO holding returned words with their address tags.
   logic [DATA_WIDTH-1:0] fifo_dat_q [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_idx_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [2:0]            occ_q;

   logic                  push, pop, out_vld, head_last;
   logic [3:0]            used;
   logic                  credit_ok;
   logic                  cnt_rd, strm_rd, rd_en, start_acc, cnt_latch;
   logic [ADDR_WIDTH-1:0] raw_cnt, clamp_cnt, rd_addr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign raw_cnt   = bus.ram_q[ADDR_WIDTH-1:0];
   assign clamp_cnt = (raw_cnt > MAX_N) ? MAX_N : raw_cnt;

   assign push      = rd_vld_q[READ_LATENCY-1];
   assign out_vld   = (occ_q != 3'd0);
   assign pop       = out_vld & bus.out_ready;
   assign head_last = out_vld && (fifo_idx_q[rd_ptr_q] == n_q);

   always_comb begin
      infl = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         infl = infl + {2'b0, rd_vld_q[i]};
      end
   end

   // Credit counts this cycle's pop as already freed: occupancy after the pop plus
   // everything still in the RAM pipeline must leave room for one more word. This is
   // what lets a READ_LATENCY+1 deep FIFO sustain one beat per cycle.
   assign used      = {1'b0, occ_q} + {1'b0, infl};
   assign credit_ok = used < (DEPTH_W + {3'b0, pop});

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      n_d         = n_q;
      next_addr_d = next_addr_q;
      done_d      = 1'b0;
      cnt_rd      = 1'b0;
      strm_rd     = 1'b0;
      start_acc   = 1'b0;
      cnt_latch   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // done_q high means this is the done cycle; a start there is dropped.
            if (bus.start && !done_q) begin
               cnt_rd    = 1'b1;
               start_acc = 1'b1;
               wait_d    = '0;
               state_d   = S_CNT_WAIT;
            end
         end
         S_CNT_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               cnt_latch = 1'b1;
               n_d       = clamp_cnt;
               if (clamp_cnt == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  next_addr_d = (ADDR_WIDTH+1)'(1);
                  state_d     = S_STREAM;
               end
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         S_STREAM: begin
            if (credit_ok) begin
               strm_rd     = 1'b1;
               next_addr_d = next_addr_q + 1'b1;
               if (next_addr_q == {1'b0, n_q}) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head_last) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read strobe is combinational so the count read goes out in the start cycle;
   // gating with rst keeps the RAM quiet while reset is held.
   assign rd_en   = (cnt_rd | strm_rd) & ~rst;
   assign rd_addr = cnt_rd  ? '0 :
                    strm_rd ? next_addr_q[ADDR_WIDTH-1:0] : addr_hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         n_q         <= '0;
         next_addr_q <= '0;
         addr_hold_q <= '0;
         done_q      <= 1'b0;
         rd_vld_q    <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            rd_tag_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         n_q         <= n_d;
         next_addr_q <= next_addr_d;
         done_q      <= done_d;
         if (rd_en) begin
            addr_hold_q <= rd_addr;
         end
         rd_vld_q[0] <= strm_rd;
         rd_tag_q[0] <= next_addr_q[ADDR_WIDTH-1:0];
         for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            rd_tag_q[i] <= rd_tag_q[i-1];
         end
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         occ_q <= occ_q + {2'b0, push} - {2'b0, pop};
      end
   end

   // Storage needs no reset: out_* are masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dat_q[wr_ptr_q] <= bus.ram_q;
         fifo_idx_q[wr_ptr_q] <= rd_tag_q[READ_LATENCY-1];
      end
   end

`ifdef VELOCITY_STREAM_OVF_EN
   logic cnt_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_err_q <= 1'b0;
      end else if (start_acc) begin
         cnt_err_q <= 1'b0;
      end else if (cnt_latch && (raw_cnt > MAX_N)) begin
         cnt_err_q <= 1'b1;
      end
   end

   assign bus.cnt_err = cnt_err_q;
`else
   assign bus.cnt_err = 1'b0;
`endif

   assign bus.busy           = (state_q != S_IDLE);
   assign bus.done           = done_q;
   assign bus.particle_count = n_q;
   assign bus.ram_address    = rd_addr;
   assign bus.ram_rden       = rd_en;
   assign bus.ram_wren       = 1'b0;
   assign bus.out_valid      = out_vld;
   assign bus.out_data       = out_vld ? fifo_dat_q[rd_ptr_q] : '0;
   assign bus.out_index      = out_vld ? fifo_idx_q[rd_ptr_q] : '0;
   assign bus.out_last       = head_last;

endmodule

// File: tb/tb_velocity_cell_streamer.sv
// Purpose     : self-checking bench for velocity_cell_streamer (table of scans plus a
//               mid-scan reset sequence), with a RAM model and a beat scoreboard.
// Latency     : n/a.
// Backpressure: drives out_ready always-high, 1-0-0 pattern or random per table entry.
module tb_velocity_cell_streamer;

   localparam int DW = 96;
   localparam int AW = 8;
   localparam int PN = 220;
   localparam int RL = 1;
`ifdef VELOCITY_STREAM_OVF_EN
   localparam bit OVF_EXP = 1'b1;
`else
   localparam bit OVF_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   velocity_cell_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   velocity_cell_streamer #(
      .DATA_WIDTH  (DW),
      .PARTICLE_NUM(PN),
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(RL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Single-port RAM model with one cycle of read latency.
   logic [DW-1:0] mem [256];
   logic [DW-1:0] ram_q_r;
   always @(posedge clk) begin
      if (bus.ram_rden) ram_q_r <= mem[bus.ram_address];
   end
   assign bus.ram_q = ram_q_r;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [DW-1:0] dat;
      logic          last;
   } beat_t;

   typedef struct {
      int count_raw;
      int ready_mode;   // 0 always ready, 1 pattern 1,0,0, 2 random
      int extra_start;  // cycle offset of a second start pulse, 0 = none
      int exp_n;
      int exp_first;    // first-beat latency, -1 = no beats expected
      int exp_done;     // done latency, -1 = not checked
      bit exp_err;
   } vec_t;

   beat_t         exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            first_seen, done_cnt, done_cyc, rd_issued, beats_acc, max_out;
   bit            done_busy, stall_pend, wren_seen;
   logic [DW-1:0] stall_dat;
   logic [AW-1:0] stall_idx;

   function automatic logic [DW-1:0] pat(input logic [7:0] salt, input int i);
      return {salt, 24'(i * 3 + 1), salt ^ 8'h5A, 24'(i), ~salt, 24'(i * 7 + 5)};
   endfunction

   function automatic logic ready_val(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 3) == 0;
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sampled on the falling edge, away from the edge the DUT acts on.
   task automatic sample();
      beat_t b;
      if (rst) return;
      if (bus.ram_wren) wren_seen = 1'b1;
      if (bus.ram_rden && bus.ram_address != '0) rd_issued++;
      if (stall_pend) begin
         check("stall_hold_valid", bus.out_valid, 1);
         check("stall_data", bus.out_data, stall_dat);
         check("stall_index", bus.out_index, stall_idx);
      end
      stall_pend = 1'b0;
      if (bus.out_valid) begin
         if (first_seen < 0) first_seen = cyc;
         if (bus.out_ready) begin
            beats_acc++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got index %0d expected no beat", bus.out_index);
            end else begin
               b = exp_q.pop_front();
               check("beat_index", bus.out_index, b.idx);
               check("beat_data", bus.out_data, b.dat);
               check("beat_last", bus.out_last, b.last);
            end
         end else begin
            stall_pend = 1'b1;
            stall_dat  = bus.out_data;
            stall_idx  = bus.out_index;
         end
      end
      if (rd_issued - beats_acc > max_out) max_out = rd_issued - beats_acc;
      if (bus.done) begin
         done_cnt++;
         if (done_cnt == 1) begin
            done_cyc  = cyc;
            done_busy = bus.busy;
         end
      end
   endtask

   // Sample this cycle, then advance to just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic load_scan(input int count_raw, input int exp_n, input logic [7:0] salt);
      beat_t b;
      mem[0] = {salt, 80'h0, 8'(count_raw)};
      for (int i = 1; i < 256; i++) mem[i] = pat(salt, i);
      exp_q.delete();
      for (int i = 1; i <= exp_n; i++) begin
         b.idx  = AW'(i);
         b.dat  = pat(salt, i);
         b.last = (i == exp_n);
         exp_q.push_back(b);
      end
      first_seen = -1;
      done_cnt   = 0;
      rd_issued  = 0;
      beats_acc  = 0;
      max_out    = 0;
      stall_pend = 1'b0;
   endtask

   task automatic run_scan(input vec_t v, input logic [7:0] salt);
      int start_cyc;
      int k;
      load_scan(v.count_raw, v.exp_n, salt);
      bus.start     = 1'b1;
      bus.out_ready = ready_val(v.ready_mode, 0);
      start_cyc     = cyc;
      tick();
      check("busy_after_start", bus.busy, 1);
      bus.start = 1'b0;
      k = 1;
      while (done_cnt == 0 && k < 3000) begin
         bus.out_ready = ready_val(v.ready_mode, k);
         bus.start     = (v.extra_start == k);
         tick();
         k++;
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("done_pulses", done_cnt, 1);
      check("busy_low_at_done", done_busy, 0);
      check("busy_idle", bus.busy, 0);
      check("particle_count", bus.particle_count, v.exp_n);
      check("cnt_err", bus.cnt_err, v.exp_err);
      check("beats_missing", exp_q.size(), 0);
      check("fifo_credit_bound", max_out <= RL + 1, 1);
      if (v.exp_first >= 0) check("first_latency", first_seen - start_cyc, v.exp_first);
      else                  check("no_beats", first_seen, -1);
      if (v.exp_done >= 0)  check("done_latency", done_cyc - start_cyc, v.exp_done);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_last"}, bus.out_last, 0);
      check({tag, "_ram_rden"}, bus.ram_rden, 0);
      check({tag, "_ram_address"}, bus.ram_address, 0);
      check({tag, "_out_data"}, bus.out_data, 0);
      check({tag, "_out_index"}, bus.out_index, 0);
      check({tag, "_particle_count"}, bus.particle_count, 0);
      check({tag, "_cnt_err"}, bus.cnt_err, 0);
   endtask

   vec_t vecs[10];
   vec_t rescan;

   initial begin
      int k;
      //          count ready xstart  n  first done  err
      vecs[0] = '{    5,   0,    0,   5,   4,    9, 1'b0};
      vecs[1] = '{    0,   0,    0,   0,  -1,    2, 1'b0};
      vecs[2] = '{    8,   1,    0,   8,   4,   -1, 1'b0};
      vecs[3] = '{  250,   0,    0, 219,   4,  223, OVF_EXP};
      vecs[4] = '{    1,   0,    0,   1,   4,    5, 1'b0};
      vecs[5] = '{   12,   2,    0,  12,   4,   -1, 1'b0};
      vecs[6] = '{    7,   0,    3,   7,   4,   11, 1'b0};
      vecs[7] = '{  219,   0,    0, 219,   4,  223, 1'b0};
      vecs[8] = '{  220,   1,    0, 219,   4,   -1, OVF_EXP};
      vecs[9] = '{    3,   0,    7,   3,   4,    7, 1'b0};
      rescan  = '{   10,   0,    0,  10,   4,   14, 1'b0};

      wren_seen     = 1'b0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      #3;
      check_reset_outputs("reset");
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b0;
      tick();

      for (int v = 0; v < 10; v++) begin
         run_scan(vecs[v], 8'(8'h10 + v));
      end

      // Reset in the middle of a 10-particle scan, then rescan.
      load_scan(10, 10, 8'h77);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      k = 0;
      while (beats_acc < 3 && k < 100) begin
         tick();
         k++;
      end
      check("reached_beat3", beats_acc, 3);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midscan_reset");
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
      run_scan(rescan, 8'h78);

      check("ram_wren_never", wren_seen, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
